// File: rtl/egress_ipg_sched_if.sv
// Bundle of the request-input, PHY-output and status signals of the egress IPG scheduler.
// The slave modport is the scheduler's view. The master modport is the view of whatever
// feeds requests and consumes IPG chunks.
interface egress_ipg_sched_if #(
    parameter int DATA_WIDTH     = 64,
    parameter int QDEPTH_LOG2    = 3,
    parameter int DROP_CNT_WIDTH = 16
);
    logic                      in_valid;
    logic [1:0]                in_type;
    logic [DATA_WIDTH-1:0]     in_data;
    logic                      in_ready;
    logic                      tx_ipg_en;
    logic [DATA_WIDTH-1:0]     tx_ipg_data;
    logic                      tx_ipg_ready;
    logic [QDEPTH_LOG2:0]      q_cnt_rreq;
    logic [QDEPTH_LOG2:0]      q_cnt_wreq;
    logic [QDEPTH_LOG2:0]      q_cnt_rresp;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt;

    modport slave (
        input  in_valid, in_type, in_data, tx_ipg_ready,
        output in_ready, tx_ipg_en, tx_ipg_data,
        output q_cnt_rreq, q_cnt_wreq, q_cnt_rresp, drop_cnt
    );

    modport master (
        output in_valid, in_type, in_data, tx_ipg_ready,
        input  in_ready, tx_ipg_en, tx_ipg_data,
        input  q_cnt_rreq, q_cnt_wreq, q_cnt_rresp, drop_cnt
    );
endinterface

// File: rtl/egress_ipg_sched.sv
// Egress IPG scheduler. Incoming chunks are sorted into three FIFOs: rreq, wreq and rresp.
// A round-robin arbiter drains the FIFOs into a registered output slot. The PHY consumes
// that slot through tx_ipg_ready. Chunks of the illegal type are dropped and counted.
module egress_ipg_sched #(
    parameter int DATA_WIDTH     = 64,
    parameter int QDEPTH_LOG2    = 3,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    egress_ipg_sched_if.slave    bus
);

    localparam int NQ    = 3;
    localparam int DEPTH = 1 << QDEPTH_LOG2;
    localparam int CNT_W = QDEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        RR_RREQ  = 2'd0,
        RR_WREQ  = 2'd1,
        RR_RRESP = 2'd2
    } rrSel_t;

    logic [DATA_WIDTH-1:0]     r_mem    [NQ][DEPTH];
    logic [QDEPTH_LOG2-1:0]    r_wrPtr  [NQ];
    logic [QDEPTH_LOG2-1:0]    r_rdPtr  [NQ];
    logic [CNT_W-1:0]          r_count  [NQ];
    rrSel_t                    r_rrPtr;
    logic                      r_txEn;
    logic [DATA_WIDTH-1:0]     r_txData;
    logic [DROP_CNT_WIDTH-1:0] r_dropCnt;

    logic [NQ-1:0] w_full;
    logic [NQ-1:0] w_empty;
    logic [NQ-1:0] w_push;
    logic [NQ-1:0] w_pop;
    logic          w_advance;
    logic          w_anyValid;
    logic          w_dropEn;
    logic          w_inReady;
    rrSel_t        w_cand1;
    rrSel_t        w_cand2;
    rrSel_t        w_grant;

    function automatic rrSel_t nextSel(input rrSel_t s);
        case (s)
            RR_RREQ: return RR_WREQ;
            RR_WREQ: return RR_RRESP;
            default: return RR_RREQ;
        endcase
    endfunction

    // Derive per-queue full/empty from the registered occupancy and decide which queue takes a push
    always_comb begin
        w_full  = '0;
        w_empty = '0;
        w_push  = '0;
        for (int q = 0; q < NQ; q++) begin
            w_full[q]  = (r_count[q] == CNT_W'(DEPTH));
            w_empty[q] = (r_count[q] == '0);
            w_push[q]  = bus.in_valid && (bus.in_type == 2'(q)) && !w_full[q];
        end
    end

    // Illegal-type chunks are always accepted and discarded; legal ones depend on their queue
    always_comb begin
        w_inReady = 1'b1;
        case (bus.in_type)
            2'b00:   w_inReady = !w_full[0];
            2'b01:   w_inReady = !w_full[1];
            2'b10:   w_inReady = !w_full[2];
            default: w_inReady = 1'b1;
        endcase
    end

    assign w_dropEn   = bus.in_valid && (bus.in_type == 2'b11);
    assign w_advance  = !r_txEn || bus.tx_ipg_ready;
    assign w_anyValid = ~&w_empty;

    // Search the queues starting at the round-robin pointer and grant the first non-empty one
    always_comb begin
        w_cand1 = nextSel(r_rrPtr);
        w_cand2 = nextSel(w_cand1);
        w_grant = r_rrPtr;
        if (!w_empty[r_rrPtr]) begin
            w_grant = r_rrPtr;
        end else if (!w_empty[w_cand1]) begin
            w_grant = w_cand1;
        end else if (!w_empty[w_cand2]) begin
            w_grant = w_cand2;
        end
    end

    // Pop the granted queue only when the output slot is free to take a new chunk
    always_comb begin
        w_pop = '0;
        if (w_advance && w_anyValid) begin
            w_pop[w_grant] = 1'b1;
        end
    end

    // Queue pointers and occupancy; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int q = 0; q < NQ; q++) begin
                r_wrPtr[q] <= '0;
                r_rdPtr[q] <= '0;
                r_count[q] <= '0;
            end
        end else begin
            for (int q = 0; q < NQ; q++) begin
                if (w_push[q]) begin
                    r_wrPtr[q] <= r_wrPtr[q] + 1'b1;
                end
                if (w_pop[q]) begin
                    r_rdPtr[q] <= r_rdPtr[q] + 1'b1;
                end
                case ({w_push[q], w_pop[q]})
                    2'b10:   r_count[q] <= r_count[q] + 1'b1;
                    2'b01:   r_count[q] <= r_count[q] - 1'b1;
                    default: r_count[q] <= r_count[q];
                endcase
            end
        end
    end

    // Queue storage needs no reset because the pointers define which entries are live
    always_ff @(posedge clk) begin
        for (int q = 0; q < NQ; q++) begin
            if (w_push[q]) begin
                r_mem[q][r_wrPtr[q]] <= bus.in_data;
            end
        end
    end

    // Output slot and arbiter pointer; the pointer moves past the granted queue only on a pop
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_txEn   <= 1'b0;
            r_txData <= '0;
            r_rrPtr  <= RR_RREQ;
        end else if (w_advance) begin
            if (w_anyValid) begin
                r_txEn   <= 1'b1;
                r_txData <= r_mem[w_grant][r_rdPtr[w_grant]];
                r_rrPtr  <= nextSel(w_grant);
            end else begin
                r_txEn   <= 1'b0;
            end
        end
    end

    // Saturating count of illegal-type chunks
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dropCnt <= '0;
        end else if (w_dropEn && (r_dropCnt != '1)) begin
            r_dropCnt <= r_dropCnt + 1'b1;
        end
    end

    assign bus.in_ready    = w_inReady;
    assign bus.tx_ipg_en   = r_txEn;
    assign bus.tx_ipg_data = r_txData;
    assign bus.q_cnt_rreq  = r_count[0];
    assign bus.q_cnt_wreq  = r_count[1];
    assign bus.q_cnt_rresp = r_count[2];
    assign bus.drop_cnt    = r_dropCnt;

endmodule

// File: tb/tb_egress_ipg_sched.sv
// Bench for egress_ipg_sched. A queue-based reference model advances one step per clock edge,
// and each scenario task compares the DUT outputs against that model or against fixed values.
module tb_egress_ipg_sched;

    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    egress_ipg_sched_if #(.DATA_WIDTH(DW), .QDEPTH_LOG2(3), .DROP_CNT_WIDTH(16)) bus ();

    egress_ipg_sched #(.DATA_WIDTH(DW), .QDEPTH_LOG2(3), .DROP_CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int numChecks = 0;
    int numFails  = 0;

    // Reference model state: one FIFO per type, the output slot, the next-preferred queue and the drop count
    logic [DW-1:0] mQ [3][$];
    logic          mEn;
    logic [DW-1:0] mData;
    int            mRr;
    logic [15:0]   mDrop;

    function automatic logic expReady(input logic [1:0] t);
        if (t == 2'b11) return 1'b1;
        return mQ[t].size() < 8;
    endfunction

    // Apply one clock edge of the model, using the inputs that are present before the edge
    task automatic modelEdge();
        int sz [3];
        int g;
        if (!rst) begin
            for (int q = 0; q < 3; q++) mQ[q].delete();
            mEn = 1'b0; mData = '0; mRr = 0; mDrop = '0;
        end else begin
            for (int q = 0; q < 3; q++) sz[q] = mQ[q].size();
            if (!mEn || bus.tx_ipg_ready) begin
                g = -1;
                for (int k = 0; k < 3; k++)
                    if (g < 0 && sz[(mRr + k) % 3] > 0) g = (mRr + k) % 3;
                if (g >= 0) begin
                    mData = mQ[g].pop_front();
                    mEn   = 1'b1;
                    mRr   = (g + 1) % 3;
                end else begin
                    mEn = 1'b0;
                end
            end
            if (bus.in_valid) begin
                if (bus.in_type == 2'b11) begin
                    if (mDrop != 16'hFFFF) mDrop = mDrop + 16'd1;
                end else if (sz[bus.in_type] < 8) begin
                    mQ[bus.in_type].push_back(bus.in_data);
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] t, input logic [DW-1:0] d, input logic rdy);
        bus.in_valid     = v;
        bus.in_type      = t;
        bus.in_data      = d;
        bus.tx_ipg_ready = rdy;
    endtask

    task automatic stepClock();
        modelEdge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'($urandom_range(0, 3)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            stepClock();
            numChecks++;
            if (bus.tx_ipg_en !== 1'b0) begin
                numFails++; $display("[TB] FAIL reset_en: got %b expected 0", bus.tx_ipg_en);
            end
            numChecks++;
            if (bus.q_cnt_rreq !== 4'd0 || bus.q_cnt_wreq !== 4'd0 || bus.q_cnt_rresp !== 4'd0) begin
                numFails++;
                $display("[TB] FAIL reset_qcnt: got %0d/%0d/%0d expected 0/0/0", bus.q_cnt_rreq, bus.q_cnt_wreq, bus.q_cnt_rresp);
            end
            numChecks++;
            if (bus.drop_cnt !== 16'd0) begin
                numFails++; $display("[TB] FAIL reset_drop: got %0d expected 0", bus.drop_cnt);
            end
        end
        rst = 1'b1;
        applyStimulus(1'b0, 2'b00, '0, 1'b1);
    endtask

    task automatic test_latency();
        applyStimulus(1'b1, 2'b00, 64'h123456781234561a, 1'b1);
        stepClock();
        numChecks++;
        if (bus.tx_ipg_en !== 1'b0) begin
            numFails++; $display("[TB] FAIL latency_early: got en=%b expected 0", bus.tx_ipg_en);
        end
        applyStimulus(1'b0, 2'b00, '0, 1'b1);
        stepClock();
        numChecks++;
        if (bus.tx_ipg_en !== 1'b1 || bus.tx_ipg_data !== 64'h123456781234561a) begin
            numFails++;
            $display("[TB] FAIL latency_out: got en=%b data=%h expected en=1 data=123456781234561a", bus.tx_ipg_en, bus.tx_ipg_data);
        end
        stepClock();
        numChecks++;
        if (bus.tx_ipg_en !== 1'b0) begin
            numFails++; $display("[TB] FAIL latency_done: got en=%b expected 0", bus.tx_ipg_en);
        end
    endtask

    task automatic test_full();
        logic [DW-1:0] first;
        logic [DW-1:0] d;
        for (int k = 0; k < 9; k++) begin
            d = {$urandom, $urandom};
            if (k == 0) first = d;
            applyStimulus(1'b1, 2'b10, d, 1'b0);
            #1;
            numChecks++;
            if (bus.in_ready !== expReady(2'b10)) begin
                numFails++; $display("[TB] FAIL full_ready_rresp[%0d]: got %b expected %b", k, bus.in_ready, expReady(2'b10));
            end
            bus.in_type = 2'b00;
            #1;
            numChecks++;
            if (bus.in_ready !== 1'b1) begin
                numFails++; $display("[TB] FAIL full_ready_rreq[%0d]: got %b expected 1", k, bus.in_ready);
            end
            bus.in_type = 2'b10;
            stepClock();
        end
        numChecks++;
        if (bus.q_cnt_rresp !== 4'd8) begin
            numFails++; $display("[TB] FAIL full_count: got %0d expected 8", bus.q_cnt_rresp);
        end
        numChecks++;
        if (bus.tx_ipg_en !== 1'b1 || bus.tx_ipg_data !== first) begin
            numFails++; $display("[TB] FAIL full_head: got en=%b data=%h expected en=1 data=%h", bus.tx_ipg_en, bus.tx_ipg_data, first);
        end
        applyStimulus(1'b1, 2'b10, {$urandom, $urandom}, 1'b0);
        #1;
        numChecks++;
        if (bus.in_ready !== 1'b0) begin
            numFails++; $display("[TB] FAIL full_reject_ready: got %b expected 0", bus.in_ready);
        end
        stepClock();
        numChecks++;
        if (bus.q_cnt_rresp !== 4'd8) begin
            numFails++; $display("[TB] FAIL full_reject_count: got %0d expected 8", bus.q_cnt_rresp);
        end
        applyStimulus(1'b0, 2'b00, '0, 1'b1);
        for (int c = 0; c < 12; c++) begin
            stepClock();
            numChecks++;
            if (bus.tx_ipg_en !== mEn || bus.tx_ipg_data !== mData || bus.q_cnt_rresp !== 4'(mQ[2].size())) begin
                numFails++;
                $display("[TB] FAIL full_drain[%0d]: got en=%b data=%h cnt=%0d expected en=%b data=%h cnt=%0d",
                         c, bus.tx_ipg_en, bus.tx_ipg_data, bus.q_cnt_rresp, mEn, mData, mQ[2].size());
            end
        end
        numChecks++;
        if (bus.tx_ipg_en !== 1'b0 || bus.q_cnt_rresp !== 4'd0) begin
            numFails++; $display("[TB] FAIL full_empty: got en=%b cnt=%0d expected en=0 cnt=0", bus.tx_ipg_en, bus.q_cnt_rresp);
        end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] pushD [6];
        logic [1:0]    pushT [6];
        logic [DW-1:0] expOrder [6];
        logic [DW-1:0] got [$];
        pushD = '{64'hA1, 64'hA2, 64'hB1, 64'hB2, 64'hC1, 64'hC2};
        pushT = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10};
        expOrder = '{64'hA1, 64'hB1, 64'hC1, 64'hA2, 64'hB2, 64'hC2};
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, pushT[k], pushD[k], 1'b0);
            stepClock();
        end
        applyStimulus(1'b0, 2'b00, '0, 1'b1);
        for (int c = 0; c < 12; c++) begin
            if (bus.tx_ipg_en === 1'b1) got.push_back(bus.tx_ipg_data);
            stepClock();
        end
        numChecks++;
        if (got.size() != 6) begin
            numFails++; $display("[TB] FAIL rr_count: got %0d chunks expected 6", got.size());
        end
        for (int k = 0; k < 6; k++) begin
            numChecks++;
            if (k >= got.size()) begin
                numFails++; $display("[TB] FAIL rr_order[%0d]: got nothing expected %h", k, expOrder[k]);
            end else if (got[k] !== expOrder[k]) begin
                numFails++; $display("[TB] FAIL rr_order[%0d]: got %h expected %h", k, got[k], expOrder[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] sent [3];
        logic [DW-1:0] got [$];
        logic          pattern [4];
        logic          prevEn;
        logic          prevRdy;
        logic [DW-1:0] prevData;
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            sent[k] = {$urandom, $urandom};
            applyStimulus(1'b1, 2'b00, sent[k], 1'b0);
            stepClock();
        end
        prevEn = 1'b0; prevRdy = 1'b1; prevData = '0;
        for (int c = 0; c < 16; c++) begin
            applyStimulus(1'b0, 2'b00, '0, pattern[c % 4]);
            numChecks++;
            if (prevEn && !prevRdy && (bus.tx_ipg_en !== 1'b1 || bus.tx_ipg_data !== prevData)) begin
                numFails++; $display("[TB] FAIL bp_hold[%0d]: got en=%b data=%h expected en=1 data=%h", c, bus.tx_ipg_en, bus.tx_ipg_data, prevData);
            end else if (bus.tx_ipg_en !== mEn || bus.tx_ipg_data !== mData) begin
                numFails++; $display("[TB] FAIL bp_model[%0d]: got en=%b data=%h expected en=%b data=%h", c, bus.tx_ipg_en, bus.tx_ipg_data, mEn, mData);
            end
            if (bus.tx_ipg_en === 1'b1 && bus.tx_ipg_ready) got.push_back(bus.tx_ipg_data);
            prevEn = bus.tx_ipg_en; prevRdy = bus.tx_ipg_ready; prevData = bus.tx_ipg_data;
            stepClock();
        end
        numChecks++;
        if (got.size() != 3) begin
            numFails++; $display("[TB] FAIL bp_count: got %0d consumed expected 3", got.size());
        end
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            numChecks++;
            if (got[k] !== sent[k]) begin
                numFails++; $display("[TB] FAIL bp_data[%0d]: got %h expected %h", k, got[k], sent[k]);
            end
        end
    endtask

    task automatic test_illegal_and_reset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 2'b11, {$urandom, $urandom}, 1'b1);
            #1;
            numChecks++;
            if (bus.in_ready !== 1'b1) begin
                numFails++; $display("[TB] FAIL illegal_ready[%0d]: got %b expected 1", k, bus.in_ready);
            end
            stepClock();
            numChecks++;
            if (bus.tx_ipg_en !== 1'b0) begin
                numFails++; $display("[TB] FAIL illegal_en[%0d]: got %b expected 0", k, bus.tx_ipg_en);
            end
        end
        applyStimulus(1'b0, 2'b00, '0, 1'b1);
        stepClock();
        numChecks++;
        if (bus.drop_cnt !== 16'd3 || bus.tx_ipg_en !== 1'b0) begin
            numFails++; $display("[TB] FAIL illegal_drop: got drop=%0d en=%b expected drop=3 en=0", bus.drop_cnt, bus.tx_ipg_en);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 2'(k % 2), {$urandom, $urandom}, 1'b0);
            stepClock();
        end
        numChecks++;
        if (bus.q_cnt_rreq !== 4'(mQ[0].size()) || bus.q_cnt_wreq !== 4'(mQ[1].size())) begin
            numFails++;
            $display("[TB] FAIL preload_cnt: got %0d/%0d expected %0d/%0d", bus.q_cnt_rreq, bus.q_cnt_wreq, mQ[0].size(), mQ[1].size());
        end
        rst = 1'b0;
        applyStimulus(1'b1, 2'b00, {$urandom, $urandom}, 1'b0);
        stepClock();
        numChecks++;
        if (bus.tx_ipg_en !== 1'b0 || bus.tx_ipg_data !== '0 || bus.drop_cnt !== 16'd0 ||
            bus.q_cnt_rreq !== 4'd0 || bus.q_cnt_wreq !== 4'd0 || bus.q_cnt_rresp !== 4'd0) begin
            numFails++;
            $display("[TB] FAIL midreset: got en=%b data=%h drop=%0d cnt=%0d/%0d/%0d expected all zero",
                     bus.tx_ipg_en, bus.tx_ipg_data, bus.drop_cnt, bus.q_cnt_rreq, bus.q_cnt_wreq, bus.q_cnt_rresp);
        end
        rst = 1'b1;
        applyStimulus(1'b0, 2'b00, '0, 1'b1);
        stepClock();
    endtask

    task automatic test_random();
        logic [1:0] t;
        for (int c = 0; c < 400; c++) begin
            t = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) t = 2'b11;
            applyStimulus(1'($urandom_range(0, 2) != 0), t, {$urandom, $urandom}, 1'($urandom_range(0, 2) == 0));
            rst = ($urandom_range(0, 99) != 0);
            #1;
            numChecks++;
            if (bus.in_ready !== expReady(t)) begin
                numFails++; $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", c, bus.in_ready, expReady(t));
            end
            stepClock();
            numChecks++;
            if (bus.tx_ipg_en !== mEn || bus.tx_ipg_data !== mData || bus.drop_cnt !== mDrop ||
                bus.q_cnt_rreq !== 4'(mQ[0].size()) || bus.q_cnt_wreq !== 4'(mQ[1].size()) ||
                bus.q_cnt_rresp !== 4'(mQ[2].size())) begin
                numFails++;
                $display("[TB] FAIL rand_state[%0d]: got en=%b data=%h drop=%0d cnt=%0d/%0d/%0d expected en=%b data=%h drop=%0d cnt=%0d/%0d/%0d",
                         c, bus.tx_ipg_en, bus.tx_ipg_data, bus.drop_cnt, bus.q_cnt_rreq, bus.q_cnt_wreq, bus.q_cnt_rresp,
                         mEn, mData, mDrop, mQ[0].size(), mQ[1].size(), mQ[2].size());
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        mEn = 1'b0; mData = '0; mRr = 0; mDrop = '0;
        applyStimulus(1'b0, 2'b00, '0, 1'b0);
        test_reset();
        test_latency();
        test_full();
        test_round_robin();
        test_backpressure();
        test_illegal_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
